systolic_ctrl: RTL and testbench
================================

Name: systolic_ctrl

Overview:
- Control and data-movement front/back end for the 2x2 systolic MAC array.
- Input side: accepts a tile's operand stream over a valid/ready interface, clears the array accumulators, and drives a0/a1/b0/b1/en_mac for k_len beats.
- Output side: snapshots p00..p11 and streams the four results out over a valid/ready interface.
- Sits between the DMA/AXI-stream side and the array. At top level, acc_clr is ORed into the array's rst.

Parameters:
- DATA_W, 8, operand width (a*/b*).
- ACC_W, 16, accumulator/result width (p*, m_data).
- KLEN_W, 8, width of k_len.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a tile. Sampled only in IDLE.
- k_len  in  KLEN_W  beats per tile. Sampled with start.
- s_valid  in  1  operand beat valid.
- s_ready  out  1  operand beat accept.
- s_data  in  4*DATA_W  packed {b1,b0,a1,a0}, a0 in LSBs.
- a0, a1, b0, b1  out  DATA_W  operands to array.
- en_mac  out  1  array accumulate enable.
- acc_clr  out  1  array accumulator clear.
- p00, p01, p10, p11  in  ACC_W  array accumulators.
- m_valid  out  1  result valid.
- m_ready  in  1  result accept.
- m_data  out  ACC_W  result word.
- m_last  out  1  marks the final word (p11).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on tile completion.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs 0, including a*/b*, en_mac, acc_clr, s_ready, m_valid, m_data, m_last, busy, done. Beat counter and snapshot registers are 0. A mid-tile reset abandons the tile; no done pulse.
- All outputs are registered except s_ready and busy, which decode state.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN.
- IDLE: start=1 latches k_len and goes to CLEAR. start is ignored in every other state.
- CLEAR: exactly 1 cycle, acc_clr=1.
  - k_len!=0: go to FEED.
  - k_len==0: go to FLUSH. Results drain as zeros.
- FEED: s_ready=1.
  - Beat accepted (s_valid&&s_ready) at edge E: a0..b1 take s_data fields and en_mac=1 for the cycle following E.
  - No beat: en_mac=0 and a*/b* hold their last values.
  - Beat counter increments per accepted beat.
  - Acceptance of beat k_len moves to FLUSH. s_ready is 0 from that edge.
- FLUSH: exactly 2 cycles.
  - Cycle 1 carries en_mac=1 for the last beat.
  - Cycle 2 has en_mac=0 and the accumulators settled.
  - On the edge leaving FLUSH, p00,p01,p10,p11 are snapshotted.
- DRAIN: m_valid=1. m_data presents the snapshot in the order p00, p01, p10, p11.
  - Advance on m_valid&&m_ready.
  - m_data and m_last stay stable while m_ready=0.
  - m_last=1 only with p11.
  - Handshake on p11: go to IDLE, m_valid=0, done=1 for 1 cycle.
  - A new start is accepted the cycle after done.
- Stalls: gaps in s_valid stretch FEED indefinitely. Backpressure on m_ready stretches DRAIN indefinitely. Neither corrupts data or the counter.
- Latency: start→first s_ready = 2 cycles. Last beat accepted→m_valid = 3 cycles.
- No arithmetic is done here. Widths pass straight through. The counter compares against the latched k_len; k_len=255 must work with no wrap.

Test Plan:
- Basic tile, bench uses the real 2x2 array (acc_clr ORed into rst).
  - Stimulus: k_len=2, beats {a0=1,a1=2,b0=3,b1=4} then {5,6,7,8}, m_ready=1.
  - Required: m_data = 38, 44, 48, 56, m_last on 56, one done pulse, en_mac high exactly 2 cycles.
- Input stalls:
  - Stimulus: same tile with s_valid low for 3 cycles between beats.
  - Required: identical results; en_mac low during the gap; a*/b* held at 1,2,3,4.
- Output backpressure:
  - Stimulus: m_ready low for 4 cycles on each word.
  - Required: m_data and m_valid stable while stalled; order and values 38, 44, 48, 56 unchanged.
- k_len=0 and back-to-back tiles:
  - Stimulus: a k_len=0 tile, then start asserted the cycle after done with k_len=1, beat {2,3,4,5}.
  - Required: first tile drains 0,0,0,0; second tile drains 8, 10, 12, 15.
- Reset mid-FEED:
  - Stimulus: assert rst after 1 of 2 beats.
  - Required: all outputs 0 immediately; busy=0; no m_valid or done. A subsequent full tile produces correct results.
- start ignored while busy:
  - Stimulus: pulse start with k_len=7 during DRAIN of a k_len=2 tile.
  - Required: no effect; the current tile completes normally; the next tile needs a fresh start.

Source files
------------

// File: rtl/systolic_ctrl.sv
// Front/back-end sequencer for the 2x2 systolic MAC array: feeds k_len operand beats in,
// then streams the four accumulator snapshots out.
module systolic_ctrl #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int KLEN_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [KLEN_W-1:0]   k_len_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [4*DATA_W-1:0] s_data_i,
    output logic [DATA_W-1:0]   a0_o,
    output logic [DATA_W-1:0]   a1_o,
    output logic [DATA_W-1:0]   b0_o,
    output logic [DATA_W-1:0]   b1_o,
    output logic                en_mac_o,
    output logic                acc_clr_o,
    input  logic [ACC_W-1:0]    p00_i,
    input  logic [ACC_W-1:0]    p01_i,
    input  logic [ACC_W-1:0]    p10_i,
    input  logic [ACC_W-1:0]    p11_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [ACC_W-1:0]    m_data_o,
    output logic                m_last_o,
    output logic                busy_o,
    output logic                done_o
);

    // state | meaning
    // IDLE  | waiting for start
    // CLEAR | one cycle of acc_clr
    // FEED  | accepting operand beats
    // FLUSH | two cycles: last MAC, then accumulators settle
    // DRAIN | streaming p00, p01, p10, p11
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [KLEN_W-1:0]       klen_q, klen_d;
    logic [KLEN_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                    flush_q, flush_d;
    logic [1:0]              widx_q, widx_d, widx_nxt;
    logic [3:0][ACC_W-1:0]   snap_q, snap_d;
    logic [4*DATA_W-1:0]     op_q, op_d;
    logic                    en_mac_q, en_mac_d;
    logic                    acc_clr_q, acc_clr_d;
    logic                    m_valid_q, m_valid_d;
    logic [ACC_W-1:0]        m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    logic                    done_q, done_d;

    assign cnt_inc  = cnt_q + KLEN_W'(1);
    assign widx_nxt = widx_q + 2'd1;

    always_comb begin
        state_d   = state_q;
        klen_d    = klen_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        widx_d    = widx_q;
        snap_d    = snap_q;
        op_d      = op_q;
        en_mac_d  = 1'b0;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    klen_d  = k_len_i;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                flush_d = 1'b0;
                state_d = (klen_q != '0) ? FEED : FLUSH;
            end
            FEED: begin
                if (s_valid_i) begin
                    op_d     = s_data_i;
                    en_mac_d = 1'b1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == klen_q) begin
                        state_d = FLUSH;
                        flush_d = 1'b0;
                    end
                end
            end
            FLUSH: begin
                if (!flush_q) begin
                    flush_d = 1'b1;
                end else begin
                    state_d  = DRAIN;
                    snap_d   = {p11_i, p10_i, p01_i, p00_i};
                    widx_d   = 2'd0;
                    m_data_d = p00_i;
                    m_last_d = 1'b0;
                end
            end
            DRAIN: begin
                if (m_ready_i) begin
                    if (widx_q == 2'd3) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        m_data_d = '0;
                        m_last_d = 1'b0;
                    end else begin
                        widx_d   = widx_nxt;
                        m_data_d = snap_q[widx_nxt];
                        m_last_d = (widx_nxt == 2'd3);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        acc_clr_d = (state_d == CLEAR);
        m_valid_d = (state_d == DRAIN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            klen_q    <= '0;
            cnt_q     <= '0;
            flush_q   <= 1'b0;
            widx_q    <= 2'd0;
            snap_q    <= '0;
            op_q      <= '0;
            en_mac_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            klen_q    <= klen_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            widx_q    <= widx_d;
            snap_q    <= snap_d;
            op_q      <= op_d;
            en_mac_q  <= en_mac_d;
            acc_clr_q <= acc_clr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
        end
    end

    assign s_ready_o = (state_q == FEED);
    assign busy_o    = (state_q != IDLE);
    assign a0_o      = op_q[0*DATA_W +: DATA_W];
    assign a1_o      = op_q[1*DATA_W +: DATA_W];
    assign b0_o      = op_q[2*DATA_W +: DATA_W];
    assign b1_o      = op_q[3*DATA_W +: DATA_W];
    assign en_mac_o  = en_mac_q;
    assign acc_clr_o = acc_clr_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_last_o  = m_last_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl driving a behavioural 2x2 MAC array.
module tb_systolic_ctrl;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int KLEN_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [KLEN_W-1:0] k_len = '0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic [4*DATA_W-1:0] s_data = '0;
    logic [DATA_W-1:0] a0, a1, b0, b1;
    logic en_mac, acc_clr;
    logic [ACC_W-1:0] p00, p01, p10, p11;
    logic m_valid;
    logic m_ready = 1'b1;
    logic [ACC_W-1:0] m_data;
    logic m_last, busy, done;

    int n_chk = 0;
    int n_pass = 0;
    int en_cnt = 0;
    int done_cnt = 0;
    int mv_cnt = 0;
    bit bp_mode = 1'b0;
    logic [ACC_W:0] exp_q[$];

    always #5 clk = ~clk;

    systolic_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .KLEN_W(KLEN_W)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .k_len_i(k_len),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .a0_o(a0), .a1_o(a1), .b0_o(b0), .b1_o(b1),
        .en_mac_o(en_mac), .acc_clr_o(acc_clr),
        .p00_i(p00), .p01_i(p01), .p10_i(p10), .p11_i(p11),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .m_last_o(m_last), .busy_o(busy), .done_o(done)
    );

    // Array model: p_ij accumulates a_i*b_j; acc_clr is ORed into its reset.
    logic arr_rst;
    assign arr_rst = rst | acc_clr;
    always_ff @(posedge clk or posedge arr_rst) begin
        if (arr_rst) begin
            p00 <= '0; p01 <= '0; p10 <= '0; p11 <= '0;
        end else if (en_mac) begin
            p00 <= p00 + ACC_W'(a0) * ACC_W'(b0);
            p01 <= p01 + ACC_W'(a0) * ACC_W'(b1);
            p10 <= p10 + ACC_W'(a1) * ACC_W'(b0);
            p11 <= p11 + ACC_W'(a1) * ACC_W'(b1);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [4*DATA_W-1:0] beat(input int x0, input int x1, input int y0, input int y1);
        return {DATA_W'(y1), DATA_W'(y0), DATA_W'(x1), DATA_W'(x0)};
    endfunction

    task automatic push4(input int d0, input int d1, input int d2, input int d3);
        exp_q.push_back({1'b0, ACC_W'(d0)});
        exp_q.push_back({1'b0, ACC_W'(d1)});
        exp_q.push_back({1'b0, ACC_W'(d2)});
        exp_q.push_back({1'b1, ACC_W'(d3)});
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks stall stability.
    logic held = 1'b0;
    logic [ACC_W:0] held_w;
    always @(negedge clk) begin
        if (!rst) begin
            if (en_mac) en_cnt++;
            if (done) done_cnt++;
            if (m_valid) mv_cnt++;
            if (held) begin
                chk("stall_valid", {31'd0, m_valid}, 32'd1);
                chk("stall_data", {15'd0, m_last, m_data}, {15'd0, held_w});
            end
            held = 1'b0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {15'd0, m_last, m_data}, 32'hffff_ffff);
                end else begin
                    logic [ACC_W:0] e;
                    e = exp_q.pop_front();
                    chk("m_data", {16'd0, m_data}, {16'd0, e[ACC_W-1:0]});
                    chk("m_last", {31'd0, m_last}, {31'd0, e[ACC_W]});
                end
            end else if (m_valid) begin
                held = 1'b1;
                held_w = {m_last, m_data};
            end
        end else begin
            held = 1'b0;
        end
    end

    // m_ready driver: in backpressure mode each word is stalled 4 cycles.
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_mode && m_valid) begin
                if (stall_cnt < 4) begin
                    m_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    m_ready = 1'b1;
                    stall_cnt = 0;
                end
            end else begin
                m_ready = 1'b1;
                stall_cnt = 0;
            end
        end
    end

    task automatic do_start(input int k);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KLEN_W'(k);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [4*DATA_W-1:0] d, output int waited);
        waited = 0;
        s_valid = 1'b1;
        s_data = d;
        while (!s_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 100) chk("s_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic finish_tile(input string name, input int en_exp);
        wait_done();
        @(posedge clk); #1;
        chk({name, "_en_mac_cycles"}, en_cnt, en_exp);
        chk({name, "_done_pulses"}, done_cnt, 32'd1);
        chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
        chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_std_tile(input string name);
        int w;
        en_cnt = 0;
        done_cnt = 0;
        push4(38, 44, 48, 56);
        do_start(2);
        send_beat(beat(1, 2, 3, 4), w);
        send_beat(beat(5, 6, 7, 8), w);
        finish_tile(name, 2);
    endtask

    initial begin
        int w;
        int n;
        int mv0;
        int d0;
        bit saw_busy;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {31'd0, |{a0, a1, b0, b1, en_mac, acc_clr, s_ready, m_valid,
                                       m_data, m_last, busy, done}}, 32'd0);
        rst = 1'b0;

        // Basic tile with latency checks.
        en_cnt = 0;
        done_cnt = 0;
        push4(38, 44, 48, 56);
        do_start(2);
        chk("clear_acc_clr", {31'd0, acc_clr}, 32'd1);
        chk("clear_s_ready", {31'd0, s_ready}, 32'd0);
        chk("clear_busy", {31'd0, busy}, 32'd1);
        send_beat(beat(1, 2, 3, 4), w);
        chk("start_to_s_ready", w, 32'd1);
        chk("beat1_en_mac", {31'd0, en_mac}, 32'd1);
        send_beat(beat(5, 6, 7, 8), w);
        chk("flush_s_ready", {31'd0, s_ready}, 32'd0);
        chk("flush_en_mac", {31'd0, en_mac}, 32'd1);
        n = 0;
        while (!m_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("last_beat_to_m_valid", n, 32'd2);
        finish_tile("basic", 2);

        // Input stalls: 3 idle cycles between beats.
        en_cnt = 0;
        done_cnt = 0;
        push4(38, 44, 48, 56);
        do_start(2);
        send_beat(beat(1, 2, 3, 4), w);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("gap_en_mac", {31'd0, en_mac}, 32'd0);
            chk("gap_operands", {a0, a1, b0, b1}, 32'h01020304);
        end
        send_beat(beat(5, 6, 7, 8), w);
        finish_tile("stall", 2);

        // Output backpressure.
        bp_mode = 1'b1;
        run_std_tile("backpressure");
        bp_mode = 1'b0;

        // k_len=0 then back-to-back start the cycle after done.
        en_cnt = 0;
        done_cnt = 0;
        push4(0, 0, 0, 0);
        do_start(0);
        wait_done();
        push4(8, 10, 12, 15);
        do_start(1);
        send_beat(beat(2, 3, 4, 5), w);
        wait_done();
        @(posedge clk); #1;
        chk("b2b_en_mac_cycles", en_cnt, 32'd1);
        chk("b2b_done_pulses", done_cnt, 32'd2);
        chk("b2b_queue_empty", exp_q.size(), 32'd0);

        // Reset mid-FEED.
        done_cnt = 0;
        do_start(2);
        send_beat(beat(1, 2, 3, 4), w);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {31'd0, |{a0, a1, b0, b1, en_mac, acc_clr, s_ready, m_valid,
                                        m_data, m_last, done}}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mv0 = mv_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_m_valid", mv_cnt - mv0, 32'd0);
        chk("midrst_no_done", done_cnt, 32'd0);
        run_std_tile("after_reset");

        // start ignored while busy.
        en_cnt = 0;
        done_cnt = 0;
        push4(38, 44, 48, 56);
        do_start(2);
        send_beat(beat(1, 2, 3, 4), w);
        send_beat(beat(5, 6, 7, 8), w);
        n = 0;
        while (!m_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b1;
        k_len = 8'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_tile("ignore_start", 2);
        d0 = done_cnt;
        saw_busy = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy) saw_busy = 1'b1;
        end
        chk("no_fresh_start_busy", {31'd0, saw_busy}, 32'd0);
        chk("no_fresh_start_done", done_cnt, d0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
